// File: rtl/id_control_idex.sv
// ID-stage control decode, load-use hazard detection and the ID/EX pipeline
// register for a classic five-stage MIPS-style pipeline.
module id_control_idex #(
  parameter int unsigned ILLCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [5:0]          id_opcode,
  input  logic [5:0]          id_funct,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic                ex_hold,
  input  logic                flush,
  output logic                hazard_stall,
  output logic                ex_valid,
  output logic                ex_regdst,
  output logic                ex_alusrc,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_memtoreg,
  output logic                ex_regwrite,
  output logic                ex_branch,
  output logic [1:0]          ex_aluop,
  output logic [5:0]          ex_funct,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd,
  output logic [ILLCNT_W-1:0] illegal_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       valid;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
  } idex_t;

  idex_t               dec;
  logic                legal;
  idex_t               idex_q, idex_d;
  logic [ILLCNT_W-1:0] cnt_q, cnt_d;

  // Opcode decode into ID/EX payload; unknown opcodes decode to all-zero control.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (id_opcode)
      OP_RTYPE: begin dec.regdst = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10; end
      OP_LW:    begin dec.alusrc = 1'b1; dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1; end
      OP_SW:    begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
      OP_BEQ:   begin dec.branch = 1'b1; dec.aluop = 2'b01; end
      OP_ADDI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      default:  legal = 1'b0;
    endcase
    dec.valid = id_valid & legal;
    dec.funct = id_funct;
    dec.rt    = id_rt;
    dec.rd    = id_rd;
  end

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  assign hazard_stall = idex_q.valid & idex_q.memread & (idex_q.rt != 5'd0) & id_valid &
                        ((idex_q.rt == id_rs) | (idex_q.rt == id_rt));

  // Next-state for ID/EX and the saturating illegal-opcode counter.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (flush) begin
      idex_d = '0;
    end else if (ex_hold) begin
      idex_d = idex_q;
    end else if (hazard_stall) begin
      idex_d = '0;
    end else if (id_valid) begin
      idex_d = dec;
      if (!legal && (cnt_q != {ILLCNT_W{1'b1}})) begin
        cnt_d = cnt_q + ILLCNT_W'(1);
      end
    end else begin
      idex_d = '0;
    end
  end

  // State registers; reset forces a bubble and clears the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_regdst   = idex_q.regdst;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
  assign ex_memtoreg = idex_q.memtoreg;
  assign ex_regwrite = idex_q.regwrite;
  assign ex_branch   = idex_q.branch;
  assign ex_aluop    = idex_q.aluop;
  assign ex_funct    = idex_q.funct;
  assign ex_rt       = idex_q.rt;
  assign ex_rd       = idex_q.rd;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_id_control_idex.sv
// Directed bench for id_control_idex with a scoreboard of expected ID/EX state.
module tb_id_control_idex;

  localparam int unsigned ILLCNT_W = 8;

  typedef struct packed {
    logic       valid;
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
  } ex_t;

  logic                clk = 1'b0;
  logic                rst, id_valid, ex_hold, flush;
  logic [5:0]          id_opcode, id_funct;
  logic [4:0]          id_rs, id_rt, id_rd;
  logic                hazard_stall;
  logic                ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite;
  logic                ex_memtoreg, ex_regwrite, ex_branch;
  logic [1:0]          ex_aluop;
  logic [5:0]          ex_funct;
  logic [4:0]          ex_rt, ex_rd;
  logic [ILLCNT_W-1:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  ex_t                 m_ex;
  logic [ILLCNT_W-1:0] m_cnt;
  ex_t                 q_ex[$];
  logic [ILLCNT_W-1:0] q_cnt[$];

  id_control_idex #(.ILLCNT_W(ILLCNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_hold(ex_hold), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_regdst(ex_regdst),
    .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_funct(ex_funct), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference decode table: valid, regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, aluop.
  function automatic ex_t ref_decode(input logic [5:0] op);
    ex_t e;
    e = '0;
    case (op)
      6'b000000: {e.valid, e.regdst, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.branch, e.aluop} = 10'b1_1000010_10;
      6'b100011: {e.valid, e.regdst, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.branch, e.aluop} = 10'b1_0110110_00;
      6'b101011: {e.valid, e.regdst, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.branch, e.aluop} = 10'b1_0101000_00;
      6'b000100: {e.valid, e.regdst, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.branch, e.aluop} = 10'b1_0000001_01;
      6'b001000: {e.valid, e.regdst, e.alusrc, e.memread, e.memwrite, e.memtoreg, e.regwrite, e.branch, e.aluop} = 10'b1_0100010_00;
      default:   e = '0;
    endcase
    return e;
  endfunction

  // One clock: drive ID inputs, check the stall request, predict and check ID/EX one cycle later.
  task automatic cyc(input string tag, input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic hold, input logic fl, input logic r, input logic haz);
    ex_t                 obs, exp_ex;
    logic [ILLCNT_W-1:0] exp_cnt;
    id_valid = v; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_hold = hold; flush = fl; rst = r;
    #1;
    checks++;
    assert (hazard_stall === haz) else begin
      errors++;
      $error("FAIL %s hazard_stall observed=%b expected=%b", tag, hazard_stall, haz);
    end
    if (r) begin
      m_ex = '0; m_cnt = '0;
    end else if (fl) begin
      m_ex = '0;
    end else if (hold) begin
      m_ex = m_ex;
    end else if (haz) begin
      m_ex = '0;
    end else if (v) begin
      m_ex = ref_decode(op);
      m_ex.funct = fn; m_ex.rt = rt; m_ex.rd = rd;
      if (!m_ex.valid && m_cnt != {ILLCNT_W{1'b1}}) m_cnt = m_cnt + ILLCNT_W'(1);
    end else begin
      m_ex = '0;
    end
    q_ex.push_back(m_ex);
    q_cnt.push_back(m_cnt);
    @(posedge clk);
    #1;
    exp_ex  = q_ex.pop_front();
    exp_cnt = q_cnt.pop_front();
    obs = {ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite,
           ex_branch, ex_aluop, ex_funct, ex_rt, ex_rd};
    checks++;
    assert (obs === exp_ex) else begin
      errors++;
      $error("FAIL %s idex observed=%h expected=%h", tag, obs, exp_ex);
    end
    checks++;
    assert (illegal_cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s illegal_cnt observed=%0d expected=%0d", tag, illegal_cnt, exp_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_funct = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_hold = 1'b0; flush = 1'b0;
    m_ex = '0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;

    //   tag            v  op        fn        rs  rt  rd  hold fl r haz
    cyc("reset",        0, 6'h00, 6'h00,  0,  0,  0, 0, 0, 1, 0);
    cyc("rtype_add",    1, 6'h00, 6'h20,  1,  2,  3, 0, 0, 0, 0);
    cyc("lw_rt5",       1, 6'h23, 6'h00,  1,  5,  0, 0, 0, 0, 0);
    cyc("loaduse_stall",1, 6'h00, 6'h20,  5,  6,  7, 0, 0, 0, 1);
    cyc("loaduse_go",   1, 6'h00, 6'h20,  5,  6,  7, 0, 0, 0, 0);
    cyc("lw_rt0",       1, 6'h23, 6'h00,  2,  0,  0, 0, 0, 0, 0);
    cyc("use_r0",       1, 6'h00, 6'h22,  0,  0,  4, 0, 0, 0, 0);
    cyc("lw_funct",     1, 6'h23, 6'h2a,  3,  9,  0, 0, 0, 0, 0);
    cyc("flush_haz",    1, 6'h3f, 6'h20,  9,  1,  2, 0, 1, 0, 1);
    cyc("beq",          1, 6'h04, 6'h11,  1,  2,  0, 0, 0, 0, 0);
    cyc("flush_hold",   1, 6'h2b, 6'h00,  4,  5,  0, 1, 1, 0, 0);
    cyc("sw",           1, 6'h2b, 6'h07,  4,  5,  0, 0, 0, 0, 0);
    cyc("addi",         1, 6'h08, 6'h15,  1,  8,  0, 0, 0, 0, 0);
    cyc("id_invalid",   0, 6'h23, 6'h00,  1,  8,  0, 0, 0, 0, 0);
    cyc("lw_rt7",       1, 6'h23, 6'h00,  1,  7,  0, 0, 0, 0, 0);
    cyc("hold_haz1",    1, 6'h00, 6'h20,  7,  3,  4, 1, 0, 0, 1);
    cyc("hold_haz2",    1, 6'h3f, 6'h20,  3,  7,  4, 1, 0, 0, 1);
    cyc("haz_release",  1, 6'h00, 6'h20,  7,  3,  4, 0, 0, 0, 1);
    cyc("after_haz",    1, 6'h00, 6'h20,  7,  3,  4, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      cyc("illegal_sat", 1, 6'h3f, 6'h00, 0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    assert (illegal_cnt === 8'd255) else begin
      errors++;
      $error("FAIL illegal_sat_final observed=%0d expected=255", illegal_cnt);
    end

    cyc("beq_load",     1, 6'h04, 6'h00,  1,  2,  0, 0, 0, 0, 0);
    cyc("beq_hold1",    1, 6'h3f, 6'h00,  0,  0,  0, 1, 0, 0, 0);
    cyc("beq_hold2",    1, 6'h3f, 6'h00,  0,  0,  0, 1, 0, 0, 0);
    cyc("beq_hold3",    1, 6'h3f, 6'h00,  0,  0,  0, 1, 0, 0, 0);
    cyc("rst_mid_hold", 1, 6'h3f, 6'h00,  0,  0,  0, 1, 0, 1, 0);
    cyc("post_rst",     1, 6'h00, 6'h20,  1,  2,  3, 0, 0, 0, 0);
    cyc("illegal_one",  1, 6'h3f, 6'h00,  0,  0,  0, 0, 0, 0, 0);
    cyc("lw_rt5_b",     1, 6'h23, 6'h00,  1,  5,  0, 0, 0, 0, 0);
    cyc("rst_override", 1, 6'h00, 6'h20,  5,  6,  7, 1, 1, 1, 1);
    cyc("idle",         0, 6'h00, 6'h00,  0,  0,  0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_control_idex.md
ID_CONTROL_IDEX -- requirements
Module: id_control_idex

Interface
REQ-001 Parameter ILLCNT_W, default 8, SHALL set the width of the illegal-opcode counter.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 id_valid  input  1  ID-stage instruction valid.
REQ-005 id_opcode  input  6  instr[31:26].
REQ-006 id_funct  input  6  instr[5:0].
REQ-007 id_rs, id_rt, id_rd  input  5 each  instruction register fields.
REQ-008 ex_hold  input  1  downstream freeze; the ID/EX register keeps its contents.
REQ-009 flush  input  1  branch-taken squash; the ID/EX register loads a bubble.
REQ-010 hazard_stall  output  1  combinational load-use stall request to the PC and IF/ID registers.
REQ-011 ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch  output  1 each  registered control bits.
REQ-012 ex_aluop  output  2  registered ALUOp; SHALL feed the ALU control unit.
REQ-013 ex_funct  output  6  registered funct; SHALL feed the ALU control unit.
REQ-014 ex_rt, ex_rd  output  5 each  registered register fields.
REQ-015 illegal_cnt  output  ILLCNT_W  saturating count of illegal opcodes accepted.

Function
REQ-016 Decode SHALL be combinational from id_opcode. Bit order: regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, then aluop.
- R-type 000000: 1,0,0,0,0,1,0, aluop=10.
- lw 100011: 0,1,1,0,1,1,0, aluop=00.
- sw 101011: 0,1,0,1,0,0,0, aluop=00.
- beq 000100: 0,0,0,0,0,0,1, aluop=01.
- addi 001000: 0,1,0,0,0,1,0, aluop=00.
REQ-017 Any other opcode SHALL be illegal: all decoded control bits 0, aluop=00, decoded valid=0.
REQ-018 A bubble SHALL mean ex_valid=0, every control bit 0, ex_aluop=00, ex_funct=000000, ex_rt=0, ex_rd=0.
REQ-019 hazard_stall SHALL equal ex_valid & ex_memread & (ex_rt!=0) & id_valid & (ex_rt==id_rs | ex_rt==id_rt).
REQ-020 ID/EX update priority at each edge SHALL be:
- rst: bubble.
- else flush: bubble.
- else ex_hold: retain all contents.
- else hazard_stall: bubble.
- else: load the decoded fields, with ex_valid = id_valid & legal.
REQ-021 When id_valid=0 on a normal load, the register SHALL load a bubble.
REQ-022 Latency from ID inputs to ex_* outputs SHALL be exactly one cycle.
REQ-023 illegal_cnt SHALL increment by 1 only on an edge taking the normal-load branch with id_valid=1 and an illegal opcode.
REQ-024 illegal_cnt SHALL saturate at all-ones and never wrap.
REQ-025 flush, ex_hold and hazard_stall edges SHALL NOT change illegal_cnt.
REQ-026 ex_funct SHALL pass id_funct unmodified for every legal opcode, not only R-type.
REQ-027 hazard_stall SHALL remain asserted while ex_hold=1 freezes a load in ID/EX.

Reset
REQ-028 On rst=1 at an edge: ID/EX SHALL hold a bubble and illegal_cnt SHALL be 0.
REQ-029 rst SHALL override flush, ex_hold and any hazard in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight ID/EX contents.
REQ-031 hazard_stall SHALL be 0 in the cycle after reset.

Verification
REQ-032 R-type add: opcode=000000, funct=100000, id_valid=1 -> next cycle ex_aluop=10, ex_funct=100000, ex_regdst=1, ex_regwrite=1, ex_valid=1.
REQ-033 Load-use: lw with rt=5, then add with rs=5 -> hazard_stall=1 for one cycle; next ID/EX is a bubble; after the stall, add loads with aluop=10.
REQ-034 lw with rt=0 followed by a consumer of $0 -> hazard_stall=0.
REQ-035 Flush and hazard together: flush=1 with hazard_stall=1 -> bubble, illegal_cnt unchanged; flush=1 with ex_hold=1 -> bubble.
REQ-036 Illegal opcode 111111 presented 300 times with ILLCNT_W=8 -> illegal_cnt=255 (saturated), ex_valid=0 throughout.
REQ-037 ex_hold=1 for 3 cycles with beq in ID/EX -> ex_branch=1 and ex_aluop=01 stable; rst=1 mid-hold -> bubble and illegal_cnt=0 next cycle.
